// File: rtl/tiny_synth_audio_pkg.sv
// Shared audio definitions for the tiny synth output path.
// Holds the default sample width and the offset-binary to two's-complement helper.
package tiny_synth_audio_pkg;

    localparam int DEFAULT_SAMPLE_WIDTH = 12;
    localparam int MAX_WIDTH = 32;

    // Flip the sample MSB, then left-justify it inside a slot_width word.
    function automatic logic [MAX_WIDTH-1:0] offset_to_signed(
        input logic [MAX_WIDTH-1:0] sample,
        input int                   slot_width,
        input int                   sample_width = DEFAULT_SAMPLE_WIDTH
    );
        logic [MAX_WIDTH-1:0] flipped;
        flipped = sample ^ (MAX_WIDTH'(1) << (sample_width - 1));
        return flipped << (slot_width - sample_width);
    endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// I2S bit/word clock generator: BCLK divider, falling-edge strobe,
// bit counter and LRCLK derived from it.
module i2s_clock_gen #(
    parameter int SLOT_WIDTH = 16,
    parameter int BCLK_DIV   = 8
) (
    input  logic main_clk,
    input  logic rst_n,
    output logic bclk_o,
    output logic lrclk_o,
    output logic fe_o,
    output logic frame_start_o
);

    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(2 * SLOT_WIDTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_WIDTH - 1);
    localparam logic [BW-1:0] RIGHT_START = BW'(SLOT_WIDTH);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic          bclk_q, bclk_d;
    logic          lrclk_q, lrclk_d;

    assign fe_o          = (div_cnt_q == DIV_LAST);
    assign frame_start_o = fe_o && (bit_cnt_q == BIT_LAST);
    assign bclk_o        = bclk_q;
    assign lrclk_o       = lrclk_q;

    always_comb begin
        div_cnt_d = fe_o ? '0 : div_cnt_q + DW'(1);
        bclk_d    = (div_cnt_d >= DIV_HALF);
        bit_cnt_d = bit_cnt_q;
        lrclk_d   = lrclk_q;
        if (fe_o) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BW'(1);
            lrclk_d   = (bit_cnt_d >= RIGHT_START);
        end
    end

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= BIT_LAST;
            lrclk_q   <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
            lrclk_q   <= lrclk_d;
        end
    end

endmodule

// File: rtl/i2s_audio_out.sv
// Philips I2S transmitter for a mono offset-binary sample, duplicated to
// both slots. Captures one sample per frame and shifts it out MSB first.
module i2s_audio_out
    import tiny_synth_audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH   = 16,
    parameter int BCLK_DIV     = 8
) (
    input  logic                    main_clk,
    input  logic                    rst_n,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    mute,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    sdata,
    output logic                    frame_strobe
);

    localparam int FW = 2 * SLOT_WIDTH;

    if (BCLK_DIV < 2 || (BCLK_DIV % 2) != 0) begin : g_bad_div
        $error("i2s_audio_out: BCLK_DIV must be even and >= 2");
    end
    if (SLOT_WIDTH < SAMPLE_WIDTH) begin : g_bad_slot
        $error("i2s_audio_out: SLOT_WIDTH must be >= SAMPLE_WIDTH");
    end

    logic fe;
    logic frame_start;

    i2s_clock_gen #(
        .SLOT_WIDTH (SLOT_WIDTH),
        .BCLK_DIV   (BCLK_DIV)
    ) u_clock_gen (
        .main_clk      (main_clk),
        .rst_n         (rst_n),
        .bclk_o        (bclk),
        .lrclk_o       (lrclk),
        .fe_o          (fe),
        .frame_start_o (frame_start)
    );

    logic [SLOT_WIDTH-1:0] word;
    logic [FW-1:0]         frame_q, frame_d;
    logic                  sdata_q, sdata_d;
    logic                  strobe_q;

    assign word = mute ? '0 : SLOT_WIDTH'(offset_to_signed(
        MAX_WIDTH'(sample_in), SLOT_WIDTH, SAMPLE_WIDTH));

    // The bit leaving the register lags one BCLK, giving the I2S delay slot.
    always_comb begin
        frame_d = frame_q;
        sdata_d = sdata_q;
        if (fe) begin
            sdata_d = frame_q[FW-1];
            frame_d = frame_start ? {word, word} : (frame_q << 1);
        end
    end

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q  <= '0;
            sdata_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            frame_q  <= frame_d;
            sdata_q  <= sdata_d;
            strobe_q <= frame_start;
        end
    end

    assign sdata        = sdata_q;
    assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_i2s_audio_out.sv
// Scoreboard bench for i2s_audio_out: stimulus pushes expected frames,
// an I2S decoder pops and compares; a cycle model checks clock timing.
module tb_i2s_audio_out;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] sample_in = 12'h800;
    logic        mute = 1'b0;
    logic        bclk, lrclk, sdata, frame_strobe;

    i2s_audio_out dut (
        .main_clk     (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .mute         (mute),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .frame_strobe (frame_strobe)
    );

    always #5 clk = ~clk;

    // Rising edges of main_clk since the last reset release.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Reference: signed value (s - 2048) scaled into a 16-bit slot.
    function automatic logic [15:0] model_word(input logic [11:0] s,
                                               input logic m);
        int v;
        if (m) return 16'h0000;
        v = int'(s) - 2048;
        return 16'(v * 16);
    endfunction

    task automatic wait_cyc(input int t);
        int g = 0;
        while (cyc < t && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (cyc < t) check("wait_timeout", cyc, t);
    endtask

    logic [11:0] dir_s [7] = '{12'h800, 12'hFFF, 12'h000, 12'hA5C,
                               12'hA5C, 12'h123, 12'hFED};
    logic        dir_m [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Capture of frame k happens at cyc == 8 + 256*k after release.
    task automatic run_frames(input int n, input int ndir);
        logic [11:0] s;
        logic        m;
        logic [15:0] w;
        for (int k = 0; k < n; k++) begin
            if (k < ndir) begin
                s = dir_s[k];
                m = dir_m[k];
            end else begin
                s = 12'($urandom);
                m = ($urandom_range(0, 7) == 0);
            end
            if (k > 0) wait_cyc(256 * k - 92);
            sample_in = s;
            mute = m;
            w = model_word(s, m);
            exp_q.push_back({w, w});
            if (k == 0) begin
                @(negedge clk);
                rst_n = 1'b1;
            end
            wait_cyc(256 * k + 9);
            sample_in = 12'($urandom);
            mute = 1'($urandom_range(0, 1));
        end
    endtask

    // Monitor: timing model checks plus I2S decode into the scoreboard.
    initial begin
        logic        pb, pl, ps, pf, prev_lr, have_left, first_rise;
        logic [15:0] sh, left;
        int          nb;
        pb = 0; pl = 1; ps = 0; pf = 0; prev_lr = 1;
        have_left = 0; first_rise = 1; sh = 0; left = 0; nb = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pb = 0; pl = 1; ps = 0; pf = 0; prev_lr = 1;
                have_left = 0; first_rise = 1; sh = 0; nb = 0;
            end else begin
                check("bclk", 32'(bclk), 32'((cyc % 8) >= 4));
                check("lrclk", 32'(lrclk),
                      32'(cyc < 8 ? 1 : int'((((cyc - 8) / 8) % 32) >= 16)));
                check("frame_strobe", 32'(frame_strobe),
                      32'(cyc >= 8 && ((cyc - 8) % 256) == 0));
                if (sdata != ps) check("sdata_edge", {pb, bclk}, 32'b10);
                if (lrclk != pl) check("lrclk_edge", {pb, bclk}, 32'b10);
                if (pf) check("strobe_width", 32'(frame_strobe), 32'd0);
                if (bclk && !pb) begin
                    sh = {sh[14:0], sdata};
                    nb++;
                    if (first_rise) begin
                        check("post_reset_lsb", 32'(sdata), 32'd0);
                        first_rise = 0;
                    end
                    if (lrclk != prev_lr) begin
                        if (!prev_lr) begin
                            left = sh;
                            have_left = (nb == 16);
                        end else if (have_left && nb == 16) begin
                            if (exp_q.size() == 0) begin
                                n_checks++;
                                n_fail++;
                                $display("FAIL frame_unexpected: got %h, required none",
                                         {left, sh});
                            end else begin
                                check("frame", {left, sh}, exp_q.pop_front());
                            end
                            have_left = 0;
                        end
                        nb = 0;
                    end
                    prev_lr = lrclk;
                end
                pb = bclk; pl = lrclk; ps = sdata; pf = frame_strobe;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        run_frames(10, 7);
        // Abort in the middle of the left slot of an unscored frame.
        wait_cyc(256 * 10 + 8 + 60);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_bclk", 32'(bclk), 32'd0);
        check("rst_lrclk", 32'(lrclk), 32'd1);
        check("rst_sdata", 32'(sdata), 32'd0);
        check("rst_strobe", 32'(frame_strobe), 32'd0);
        repeat (2) @(negedge clk);
        run_frames(8, 0);
        wait_cyc(256 * 8 + 20);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
